// File: rtl/fifo_reader.sv
// Unpacks W-bit words from an upstream FIFO into NB = W/B beats, least-significant beat first.
// Handshaked output with backpressure, flush, and a wrapping count of fully emitted words.
//
// state | meaning
// EMPTY | no word held; pop the FIFO head when one is available
// HOLD  | r_word valid, presenting beat r_beat
module fifo_reader #(
  parameter int W = 32,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_data,
  output logic         fifo_pop,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [B-1:0] out_data,
  output logic         out_last,
  input  logic         flush,
  output logic [15:0]  words_done
);

  localparam int NB = W / B;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          r_word_q, r_word_d;
  logic [BW-1:0]         r_beat_q, r_beat_d;
  logic [15:0]           words_done_q, words_done_d;
  logic                  reset_dly_q, reset_dly_d;
  logic [NB-1:0][B-1:0]  word_beats;
  logic                  accept;
  logic                  last_acc;

  assign word_beats = r_word_q;
  assign words_done = words_done_q;

  always_comb begin
    // Outputs are gated by reset so an abandoned word never shows during the reset cycle.
    out_valid = (state_q == HOLD) & ~reset;
    out_last  = out_valid & (r_beat_q == LAST_BEAT);
    out_data  = word_beats[r_beat_q];
    accept    = out_valid & out_ready;
    last_acc  = accept & out_last;
    // reset_dly_q keeps the first cycle after reset free of pops.
    fifo_pop  = ~fifo_empty & ~flush & ~reset & ~reset_dly_q &
                ((state_q == EMPTY) | last_acc);

    state_d      = state_q;
    r_word_d     = r_word_q;
    r_beat_d     = r_beat_q;
    words_done_d = words_done_q;
    reset_dly_d  = reset;

    if (reset) begin
      state_d      = EMPTY;
      r_beat_d     = '0;
      words_done_d = '0;
    end else if (flush) begin
      state_d  = EMPTY;
      r_beat_d = '0;
    end else begin
      if (last_acc) begin
        words_done_d = words_done_q + 16'd1;
        state_d      = EMPTY;
      end else if (accept) begin
        r_beat_d = r_beat_q + BW'(1);
      end
      if (fifo_pop) begin
        r_word_d = fifo_data;
        r_beat_d = '0;
        state_d  = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    r_word_q     <= r_word_d;
    r_beat_q     <= r_beat_d;
    words_done_q <= words_done_d;
    reset_dly_q  <= reset_dly_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (fifo_pop && fifo_empty) $fatal(1, "fifo_reader: pop while FIFO empty");
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue-based FIFO source feeds the DUT, and a
// transaction-level model predicts the beat stream, pops and word count.
module tb_fifo_reader;
  localparam int W  = 32;
  localparam int B  = 8;
  localparam int NB = W / B;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_pop;
  logic          out_valid;
  logic          out_ready;
  logic [B-1:0]  out_data;
  logic          out_last;
  logic          flush;
  logic [15:0]   words_done;

  always #5 clk = ~clk;

  fifo_reader #(.W(W), .B(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .flush      (flush),
    .words_done (words_done)
  );

  typedef struct {
    logic [B-1:0] data;
    bit           last;
  } beat_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  beat_t        exp_q[$];        // remaining beats of the word the DUT should be holding
  logic [W-1:0] src_q[$];        // upstream FIFO contents
  logic [15:0]  exp_done = '0;
  bit           post_reset = 0;
  bit           consume = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit           acc;
    bit           lst;
    bit           exp_pop;
    beat_t        bt;
    logic [W-1:0] w;
    if (reset) begin
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_last",  {31'd0, out_last},  32'd0);
      chk("rst_pop",   {31'd0, fifo_pop},  32'd0);
      exp_q.delete();
      exp_done   = '0;
      post_reset = 1;
    end else begin
      chk("words_done", {16'd0, words_done}, {16'd0, exp_done});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      acc = 0;
      lst = 0;
      if (exp_q.size() > 0) begin
        chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].data});
        chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
        acc = out_ready;
        lst = exp_q[0].last;
      end
      exp_pop = !fifo_empty && !flush && !post_reset && (exp_q.size() == 0 || (acc && lst));
      chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});
      if (acc) begin
        void'(exp_q.pop_front());
        if (lst && !flush) exp_done++;
      end
      if (flush) exp_q.delete();
      if (exp_pop) begin
        w = src_q[0];
        for (int i = 0; i < NB; i++) begin
          bt.data = w[B*i +: B];
          bt.last = (i == NB - 1);
          exp_q.push_back(bt);
        end
      end
      post_reset = 0;
    end
    if (fifo_pop && src_q.size() > 0) consume = 1;
  end

  task automatic step(input bit rdy, input bit fl, input bit rs);
    @(posedge clk);
    #1;
    if (consume) begin
      void'(src_q.pop_front());
      consume = 0;
    end
    out_ready  = rdy;
    flush      = fl;
    reset      = rs;
    fifo_empty = (src_q.size() == 0);
    fifo_data  = fifo_empty ? W'($urandom) : src_q[0];
  endtask

  initial begin
    int k;
    reset      = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    repeat (3) step(0, 0, 1);

    // single word
    src_q.push_back(32'h44332211);
    repeat (7) step(1, 0, 0);

    // back-to-back words, no bubble
    src_q.push_back(32'hDDCCBBAA);
    src_q.push_back(32'h04030201);
    repeat (11) step(1, 0, 0);

    // backpressure after the first beat: 0x22 must hold
    src_q.push_back(32'h44332211);
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    repeat (5) step(1, 0, 0);

    // empty FIFO
    repeat (10) step(1, 0, 0);

    // flush mid-word after 0x22 accepted
    src_q.push_back(32'h44332211);
    src_q.push_back(32'h88776655);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (8) step(1, 0, 0);

    // reset mid-word during beat 1
    src_q.push_back(32'hA4A3A2A1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    src_q.push_back(32'hB4B3B2B1);
    repeat (10) step(1, 0, 0);

    // randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 4) src_q.push_back(W'($urandom));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    end

    // drain with a bounded budget
    k = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && k < 200) begin
      step(1, 0, 0);
      k++;
    end
    chk("drain_remaining", src_q.size() + exp_q.size(), 32'd0);
    repeat (2) step(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
